// File: rtl/div_mr_seq.sv
// -----------------------------------------------------------------------------
// div_mr_seq -- parametrised multi-radix sequential restoring divider.
//
// Divides an NW-bit dividend by a DW-bit divisor. Each iteration cycle resolves
// BPC quotient bits, MSB first. The divider supports unsigned and signed
// (truncating) operands, flags divide-by-zero, and takes a fast path when the
// dividend magnitude is smaller than the divisor magnitude.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset (aborts any operation in flight)
//   start      operation request, sampled only while idle
//   sgn        1 = operands are two's complement (sampled with start)
//   A          NW-bit dividend (sampled with start)
//   B          DW-bit divisor (sampled with start)
//   busy       high while an operation is in flight
//   done       one-cycle pulse; qu/Res/dbz are valid from this cycle onward
//   qu         NW-bit quotient
//   Res        DW-bit remainder
//   dbz        divide-by-zero flag, valid with done
//   dbg_state  current controller state (IDLE/PREP/ITER/FIN)
//
// Handshake: a request is accepted on any rising edge where start = 1 and the
// controller is idle (busy = 0). The done cycle counts as idle, so a new start
// may be presented in the same cycle as done. start while busy = 1 is dropped,
// never queued. Results stay on qu/Res/dbz until the next completion or reset.
// -----------------------------------------------------------------------------
module div_mr_seq #(
    parameter int DW  = 32,
    parameter int NW  = 64,
    parameter int BPC = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          sgn,
    input  logic [NW-1:0] A,
    input  logic [DW-1:0] B,
    output logic          busy,
    output logic          done,
    output logic [NW-1:0] qu,
    output logic [DW-1:0] Res,
    output logic          dbz,
    output logic [1:0]    dbg_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PREP = 2'd1;
    localparam logic [1:0] S_ITER = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    localparam int ITERS = NW / BPC;
    localparam int CW    = (ITERS > 1) ? $clog2(ITERS) : 1;

    logic [1:0]    state_q, state_d;
    logic [NW-1:0] a_q, a_d;       // raw dividend, then its magnitude being shifted out
    logic [DW-1:0] b_q, b_d;       // raw divisor, then its magnitude
    logic          sgn_q, sgn_d;
    logic          qneg_q, qneg_d; // quotient must be negated in FIN
    logic          rneg_q, rneg_d; // remainder must be negated in FIN
    logic          zdiv_q, zdiv_d; // operation hit the divide-by-zero path
    // The partial remainder after every restoring step is below |B|, so it
    // fits in DW bits; only the freshly shifted value needs DW+1 bits.
    logic [DW-1:0] pr_q, pr_d;
    logic [NW-1:0] quo_q, quo_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [NW-1:0] qu_q, qu_d;
    logic [DW-1:0] res_q, res_d;
    logic          dbz_q, dbz_d;

    // PREP helpers
    logic          sa, sb;
    logic [NW-1:0] a_mag;
    logic [DW-1:0] b_mag;

    // ITER datapath variables
    logic [NW-1:0] a_v;
    logic [DW-1:0] pr_v;
    logic [NW-1:0] quo_v;
    logic [DW:0]   pr_sh;
    logic [DW+1:0] trial;          // extra MSB is the borrow of the trial subtract

    always_comb begin
        sa    = sgn_q & a_q[NW-1];
        sb    = sgn_q & b_q[DW-1];
        a_mag = sa ? (~a_q + 1'b1) : a_q;
        b_mag = sb ? (~b_q + 1'b1) : b_q;
    end

    always_comb begin
        a_v   = a_q;
        pr_v  = pr_q;
        quo_v = quo_q;
        pr_sh = '0;
        trial = '0;
        for (int i = 0; i < BPC; i++) begin
            pr_sh = {pr_v, a_v[NW-1]};
            trial = {1'b0, pr_sh} - {2'b00, b_q};
            a_v   = {a_v[NW-2:0], 1'b0};
            // No borrow: the difference is below |B| and replaces the remainder.
            pr_v  = trial[DW+1] ? pr_sh[DW-1:0] : trial[DW-1:0];
            quo_v = {quo_v[NW-2:0], ~trial[DW+1]};
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        zdiv_d  = zdiv_q;
        pr_d    = pr_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        qu_d    = qu_q;
        res_d   = res_q;
        dbz_d   = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    sgn_d   = sgn;
                    busy_d  = 1'b1;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                qneg_d = sa ^ sb;
                rneg_d = sa;
                a_d    = a_mag;
                b_d    = b_mag;
                if (b_q == '0) begin
                    zdiv_d  = 1'b1;
                    quo_d   = '1;
                    pr_d    = a_q[DW-1:0];
                    state_d = S_FIN;
                end else if (a_mag < NW'(b_mag)) begin
                    // |A| < |B| so |A| already fits in DW bits.
                    zdiv_d  = 1'b0;
                    quo_d   = '0;
                    pr_d    = a_mag[DW-1:0];
                    state_d = S_FIN;
                end else begin
                    zdiv_d  = 1'b0;
                    quo_d   = '0;
                    pr_d    = '0;
                    cnt_d   = '0;
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                a_d   = a_v;
                pr_d  = pr_v;
                quo_d = quo_v;
                if (cnt_q == CW'(ITERS - 1)) begin
                    state_d = S_FIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FIN: begin
                qu_d    = (!zdiv_q && qneg_q) ? (~quo_q + 1'b1) : quo_q;
                res_d   = (!zdiv_q && rneg_q) ? (~pr_q + 1'b1) : pr_q;
                dbz_d   = zdiv_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            zdiv_q  <= 1'b0;
            pr_q    <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            qu_q    <= '0;
            res_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            zdiv_q  <= zdiv_d;
            pr_q    <= pr_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            qu_q    <= qu_d;
            res_q   <= res_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign qu        = qu_q;
    assign Res       = res_q;
    assign dbz       = dbz_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_div_mr_seq.sv
// Bench for div_mr_seq: three instances (BPC = 1, 2, 4) share the same
// operand inputs and are compared against a plain-arithmetic reference model.
module tb_div_mr_seq;
    localparam int NW = 64;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          sgn;
    logic [NW-1:0] a;
    logic [DW-1:0] b;

    logic          busy_v [3];
    logic          done_v [3];
    logic          dbz_v  [3];
    logic [NW-1:0] qu_v   [3];
    logic [DW-1:0] res_v  [3];
    logic [1:0]    st_v   [3];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    div_mr_seq #(.DW(DW), .NW(NW), .BPC(1)) u_bpc1 (
        .clk(clk), .reset(reset), .start(start), .sgn(sgn), .A(a), .B(b),
        .busy(busy_v[0]), .done(done_v[0]), .qu(qu_v[0]), .Res(res_v[0]),
        .dbz(dbz_v[0]), .dbg_state(st_v[0])
    );
    div_mr_seq #(.DW(DW), .NW(NW), .BPC(2)) u_bpc2 (
        .clk(clk), .reset(reset), .start(start), .sgn(sgn), .A(a), .B(b),
        .busy(busy_v[1]), .done(done_v[1]), .qu(qu_v[1]), .Res(res_v[1]),
        .dbz(dbz_v[1]), .dbg_state(st_v[1])
    );
    div_mr_seq #(.DW(DW), .NW(NW), .BPC(4)) u_bpc4 (
        .clk(clk), .reset(reset), .start(start), .sgn(sgn), .A(a), .B(b),
        .busy(busy_v[2]), .done(done_v[2]), .qu(qu_v[2]), .Res(res_v[2]),
        .dbz(dbz_v[2]), .dbg_state(st_v[2])
    );

    // Reference: truncating division on magnitudes, then sign fix-up.
    task automatic model(input logic [NW-1:0] ma, input logic [DW-1:0] mb,
                         input logic ms, output logic [NW-1:0] q,
                         output logic [DW-1:0] r, output logic z, output logic fast);
        logic [NW-1:0] am;
        logic [NW-1:0] bm;
        logic [NW-1:0] rf;
        logic          na;
        logic          nb;
        na = ms && ma[NW-1];
        nb = ms && mb[DW-1];
        if (mb == 0) begin
            q = '1;
            r = ma[DW-1:0];
            z = 1'b1;
            fast = 1'b1;
        end else begin
            am = na ? -ma : ma;
            bm = {32'b0, (nb ? -mb : mb)};
            q  = am / bm;
            rf = am % bm;
            r  = rf[DW-1:0];
            z  = 1'b0;
            fast = (am < bm);
            if (na ^ nb) q = -q;
            if (na) r = -r;
        end
    endtask

    // One operation through all three instances. poke > 0 pulses start
    // (with junk operands) on edge k+poke while everything is still busy.
    task automatic run_op(input string tag, input logic [NW-1:0] op_a,
                          input logic [DW-1:0] op_b, input logic op_s, input int poke);
        logic [NW-1:0] eq;
        logic [DW-1:0] er;
        logic          ez;
        logic          fast;
        int            seen [3];
        int            exp_lat;
        bit            all_seen;
        model(op_a, op_b, op_s, eq, er, ez, fast);
        a = op_a;
        b = op_b;
        sgn = op_s;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = {$urandom, $urandom};
        b = $urandom;
        sgn = 1'($urandom_range(0, 1));
        for (int i = 0; i < 3; i++) begin
            seen[i] = -1;
            n_vec++;
            if (busy_v[i] !== 1'b1) begin
                n_err++;
                $display("FAIL %s busy_after_start bpc%0d: got %b want 1", tag, 1 << i, busy_v[i]);
            end
        end
        all_seen = 1'b0;
        for (int cyc = 1; cyc <= 100 && !all_seen; cyc++) begin
            if (cyc == poke) begin
                start = 1'b1;
                a = {$urandom, $urandom};
                b = $urandom_range(1, 1000);
            end
            @(posedge clk); #1;
            start = 1'b0;
            all_seen = 1'b1;
            for (int i = 0; i < 3; i++) begin
                if (seen[i] >= 0 && seen[i] == cyc - 1) begin
                    n_vec++;
                    if (done_v[i] !== 1'b0) begin
                        n_err++;
                        $display("FAIL %s done_pulse_width bpc%0d: got %b want 0", tag, 1 << i, done_v[i]);
                    end
                end
                if (seen[i] < 0) begin
                    if (done_v[i] === 1'b1) begin
                        seen[i] = cyc;
                        n_vec++;
                        if (busy_v[i] !== 1'b0) begin
                            n_err++;
                            $display("FAIL %s busy_at_done bpc%0d: got %b want 0", tag, 1 << i, busy_v[i]);
                        end
                    end else if (busy_v[i] !== 1'b1) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL %s busy_dropped bpc%0d cycle %0d: got %b want 1", tag, 1 << i, cyc, busy_v[i]);
                        seen[i] = -2;
                    end
                end
                if (seen[i] == -1) all_seen = 1'b0;
            end
        end
        for (int i = 0; i < 3; i++) begin
            exp_lat = fast ? 2 : 2 + NW / (1 << i);
            n_vec++;
            if (seen[i] != exp_lat) begin
                n_err++;
                $display("FAIL %s latency bpc%0d: got %0d want %0d", tag, 1 << i, seen[i], exp_lat);
            end
            n_vec++;
            if (qu_v[i] !== eq) begin
                n_err++;
                $display("FAIL %s qu bpc%0d A=%h B=%h s=%b: got %h want %h", tag, 1 << i, op_a, op_b, op_s, qu_v[i], eq);
            end
            n_vec++;
            if (res_v[i] !== er) begin
                n_err++;
                $display("FAIL %s Res bpc%0d A=%h B=%h s=%b: got %h want %h", tag, 1 << i, op_a, op_b, op_s, res_v[i], er);
            end
            n_vec++;
            if (dbz_v[i] !== ez) begin
                n_err++;
                $display("FAIL %s dbz bpc%0d A=%h B=%h: got %b want %b", tag, 1 << i, op_a, op_b, dbz_v[i], ez);
            end
        end
    endtask

    task automatic check_cleared(input string tag);
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if ({busy_v[i], done_v[i], dbz_v[i], qu_v[i], res_v[i]} !== '0) begin
                n_err++;
                $display("FAIL %s bpc%0d: got busy=%b done=%b dbz=%b qu=%h Res=%h want all 0",
                         tag, 1 << i, busy_v[i], done_v[i], dbz_v[i], qu_v[i], res_v[i]);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        sgn = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(posedge clk);
        #1;
        check_cleared("reset_state");
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned();
        run_op("u_100_7", 64'd100, 32'd7, 1'b0, 0);
        run_op("u_5_9_fast", 64'd5, 32'd9, 1'b0, 0);
    endtask

    task automatic test_dbz();
        run_op("dbz", 64'h1234, 32'd0, 1'b0, 0);
        run_op("after_dbz", 64'd9, 32'd3, 1'b0, 0);
        run_op("dbz_signed", 64'hFFFF_FFFF_8000_00F0, 32'd0, 1'b1, 0);
    endtask

    task automatic test_signed();
        run_op("s_m7_2", 64'hFFFF_FFFF_FFFF_FFF9, 32'd2, 1'b1, 0);
        run_op("s_7_m2", 64'd7, 32'hFFFF_FFFE, 1'b1, 0);
        run_op("s_fast_neg", 64'hFFFF_FFFF_FFFF_FFFB, 32'd9, 1'b1, 0);
        run_op("s_overflow", 64'h8000_0000_0000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    endtask

    task automatic test_max_operands();
        run_op("max_u", 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
        run_op("a_eq_b", 64'h0000_0000_DEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 0);
    endtask

    task automatic test_mid_start();
        run_op("mid_start", 64'd100, 32'd7, 1'b0, 10);
    endtask

    task automatic test_reset_mid();
        int pulses [3];
        a = 64'd100;
        b = 32'd7;
        sgn = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (21) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_cleared("reset_mid");
        for (int i = 0; i < 3; i++) pulses[i] = 0;
        repeat (80) begin
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) if (done_v[i] === 1'b1) pulses[i]++;
        end
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (pulses[i] != 0) begin
                n_err++;
                $display("FAIL reset_mid_no_done bpc%0d: got %0d pulses want 0", 1 << i, pulses[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        run_op("b2b_first", 64'd100, 32'd7, 1'b0, 0);
        n_vec++;
        if (done_v[0] !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_done_cycle: got %b want 1", done_v[0]);
        end
        run_op("b2b_second", 64'd9, 32'd3, 1'b0, 0);
    endtask

    task automatic test_random();
        logic [NW-1:0] ra;
        logic [DW-1:0] rb;
        logic          rs;
        for (int n = 0; n < 500; n++) begin
            ra = {$urandom, $urandom};
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: ra = {32'b0, $urandom};
                2: rb = $urandom_range(0, 1) ? 32'd1 : 32'hFFFF_FFFF;
                3: begin ra = 64'h8000_0000_0000_0000; rb = 32'hFFFF_FFFF; end
                4: rb = $urandom_range(1, 255);
                5: ra = {{56{ra[63]}}, ra[7:0]};
                default: ;
            endcase
            run_op("random", ra, rb, rs, 0);
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_dbz();
        test_signed();
        test_max_operands();
        test_mid_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
